// File: rtl/interp_xor_prep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interp_xor_prep: word-serial r = a ^ b ^ c with (x+1) divisibility flag   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module interp_xor_prep #(
  parameter int N = 4460,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         parity,
  output logic         not_div
);

  localparam int NW  = (N + W - 1) / W;
  localparam int NP  = NW * W;
  localparam int PAD = NP - N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [NP-1:0] sa_q, sb_q, sc_q, out_q;
  logic [15:0]   cnt_q;
  logic          par_q, busy_q, done_q, parity_q, not_div_q;

  logic [W-1:0]  w_d;
  logic          par_d;
  logic [NP-1:0] a_pad_d, b_pad_d, c_pad_d;

  // Operands are left-aligned so the MSB word leaves the shifters first.
  always_comb begin
    a_pad_d = NP'(a) << PAD;
    b_pad_d = NP'(b) << PAD;
    c_pad_d = NP'(c) << PAD;
    w_d     = sa_q[NP-1 -: W] ^ sb_q[NP-1 -: W] ^ sc_q[NP-1 -: W];
    par_d   = par_q ^ (^w_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      sc_q      <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
      not_div_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            sa_q      <= a_pad_d;
            sb_q      <= b_pad_d;
            sc_q      <= c_pad_d;
            out_q     <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            parity_q  <= 1'b0;
            not_div_q <= 1'b0;
          end
        end
        S_RUN: begin
          out_q <= (out_q << W) | NP'(w_d);
          par_q <= par_d;
          sa_q  <= sa_q << W;
          sb_q  <= sb_q << W;
          sc_q  <= sc_q << W;
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == 16'(NW - 1)) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            parity_q  <= par_d;
            not_div_q <= par_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out     = out_q[NP-1 -: N];
  assign busy    = busy_q;
  assign done    = done_q;
  assign parity  = parity_q;
  assign not_div = not_div_q;

endmodule
`default_nettype wire
